fir_burst_arbiter: RTL
======================

Name: fir_burst_arbiter

Overview:
Shares the single FIR_Filter datapath between NREQ sample streams. Each stream gets the filter in whole bursts, arbitrated round-robin. After every burst the arbiter flushes the FIR delay line with zeros, so no history leaks between requesters. It tags every filtered output with the owning requester ID and an end-of-burst marker. It sits between the sample sources and FIR_Filter (drives x_in, receives y_out).

Parameters:
NREQ, 2, number of requesters (>=2)
TAPS, 4, FIR tap count; sets flush length (>=2)
FIR_LAT, 1, cycles from a sample on fir_x to its result on fir_y (>=1)
TIMEOUT, 16, stall-cycle limit (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
req  in  NREQ  burst request per requester
grant  out  NREQ  one-hot burst ownership
s_data  in  8*NREQ  sample per requester, requester i at bits [8i+7:8i]
s_valid  in  NREQ  sample valid per requester
s_last  in  NREQ  final sample of burst
s_ready  out  NREQ  sample accepted when s_valid & s_ready
fir_x  out  8  to FIR_Filter x_in
fir_y  in  16  from FIR_Filter y_out
m_data  out  16  filtered sample (= fir_y)
m_valid  out  1  m_data belongs to an accepted sample
m_id  out  IDW  owner of m_data, IDW = max(1,$clog2(NREQ))
m_last  out  1  m_data is the last result of a burst

Behaviour:
- Reset (rst=0, async): state IDLE; grant, s_ready, fir_x, m_valid, m_id, m_last, tag pipe, flush counter all 0. RR pointer last=NREQ-1, so requester 0 wins first.
- FSM states: IDLE, STREAM, FLUSH.
- IDLE: fir_x=0.
  - If |req, winner = first set req scanning from (last+1) mod NREQ upward, with wrap.
  - Next edge: grant <= onehot(winner), last <= winner, state <= STREAM.
  - Arbitration takes exactly one IDLE cycle.
- STREAM:
  - s_ready[g]=1 for the granted g only; all other s_ready=0.
  - On accept: fir_x <= sample at next edge; tag {valid=1, id=g, last=s_last[g]} enters tag pipe.
  - Bubble (s_valid[g]=0): fir_x <= 0 and tag valid=0. The zero is fed to the filter as signal.
  - Dropping req[g] mid-burst is ignored. Only an accepted s_last ends the burst.
  - On accept with s_last: grant <= 0, s_ready <= 0, cnt <= TAPS-1, state <= FLUSH.
- FLUSH: fir_x=0, s_ready=0, grant=0. cnt decrements each cycle; when cnt==1, state <= IDLE. Length is exactly TAPS-1 cycles.
- Gap between bursts: the last sample is followed by TAPS-1 flush zeros plus 1 IDLE cycle before the next burst's first sample.
- Tag pipe: FIR_LAT registers, aligned so that m_valid, m_id and m_last describe fir_y in the same cycle.
  - m_data = fir_y at all times; consumers qualify it with m_valid.
  - The pipe shifts every cycle in every state; FLUSH and IDLE inject valid=0.
- The 8-bit sample is passed through unsigned and unchanged; no arithmetic is performed in the arbiter.
- Simultaneous req on all lines with one holder: strict rotation; no requester waits more than NREQ-1 bursts.

Optional Feature:
Macro FIR_ARB_TIMEOUT_EN.
- Defined: in STREAM, a stall counter counts consecutive cycles with s_valid[g]=0 and clears on accept. At TIMEOUT, the burst is aborted: enter FLUSH as if s_last had been accepted. The previous tag's m_last is not retro-set. A 1-cycle pulse is output on abort (port abort, 1 bit, reset 0).
- Undefined: no counter and no abort port; a burst holds the filter indefinitely until s_last.

Test Plan:
- Reset: hold rst=0 with random inputs -> grant=0, s_ready=0, fir_x=0, m_valid=0. Release -> stays IDLE while req=0.
- Single burst (NREQ=2, TAPS=4, FIR_LAT=1):
  - Stimulus: req[0] at cycle 0; samples 1,2,3 with s_last on 3.
  - grant=01 at cycle 1.
  - fir_x = 1,2,3 on cycles 2-4, then 0 on cycles 5-7 (flush) and 8 (IDLE).
  - m_valid on cycles 3-5 with m_id=0 and m_last only on 5.
- Contention: req=11 held -> bursts granted 0,1,0,1. Each new grant appears exactly TAPS=4 cycles after the previous burst's last fir_x sample.
- Bubble: s_valid[0] low for one cycle between samples 5 and 6 -> fir_x = 5,0,6; m_valid low for the slot aligned to the 0.
- Reset mid-STREAM: assert rst while fir_x=7 -> grant, fir_x and m_valid drop to 0 without a clock edge. After release, req[0] wins first.
- With FIR_ARB_TIMEOUT_EN and TIMEOUT=16: granted source stalls 16 cycles -> abort pulse, then FLUSH of 3 cycles, then the other requester is granted.

Source files
------------

// File: rtl/fir_burst_arbiter.sv
// fir_burst_arbiter: lends one FIR_Filter datapath to NREQ sample streams.
// Ownership is granted in whole bursts, round-robin. After each burst the
// FIR delay line is flushed with TAPS-1 zeros so that no history leaks from
// one requester to the next. Every filtered output is tagged with its
// owner's ID and an end-of-burst marker, aligned to fir_y.
// Optional build macro: FIR_ARB_TIMEOUT_EN. When it is defined, a stalled
// burst is aborted after TIMEOUT idle cycles and the abort port pulses.
`timescale 1ns/1ps

module fir_burst_arbiter #(
  parameter int NREQ    = 2,
  parameter int TAPS    = 4,
  parameter int FIR_LAT = 1
`ifdef FIR_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 16
`endif
  , localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   grant,
  input  logic [8*NREQ-1:0] s_data,
  input  logic [NREQ-1:0]   s_valid,
  input  logic [NREQ-1:0]   s_last,
  output logic [NREQ-1:0]   s_ready,
  output logic [7:0]        fir_x,
  input  logic [15:0]       fir_y,
  output logic [15:0]       m_data,
  output logic              m_valid,
  output logic [IDW-1:0]    m_id,
  output logic              m_last
`ifdef FIR_ARB_TIMEOUT_EN
  , output logic            abort
`endif
);

  localparam int CW = $clog2(TAPS);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
    logic           last;
  } tag_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] last_q, last_d;   // last winner; equals the owner while streaming
  logic [NREQ-1:0] grant_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [7:0]     x_d;
  tag_t           tag_in;
  tag_t           tag_q [FIR_LAT+1];  // stage 0 travels alongside fir_x
  logic [IDW-1:0] win, scan_id;
  logic           found;
  logic [7:0]     s_data_a [NREQ];
  logic           acc;

`ifdef FIR_ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0]  stall_q, stall_d;
  logic           abort_d;
`endif

  for (genvar i = 0; i < NREQ; i++) begin : g_split
    assign s_data_a[i] = s_data[8*i+7 : 8*i];
  end

  assign acc     = (state_q == STREAM) && s_valid[last_q];
  assign s_ready = grant;             // grant is only non-zero while streaming
  assign m_data  = fir_y;
  assign m_valid = tag_q[FIR_LAT].valid;
  assign m_id    = tag_q[FIR_LAT].id;
  assign m_last  = tag_q[FIR_LAT].last;

  // Round-robin search: first active request after the previous winner.
  always_comb begin
    win     = last_q;
    found   = 1'b0;
    scan_id = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_id = IDW'((int'(last_q) + k) % NREQ);
      if (!found && req[scan_id]) begin
        win   = scan_id;
        found = 1'b1;
      end
    end
  end

  // Next-state, next-grant and filter input selection.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one unassigned and infers a latch.
    state_d = state_q;
    grant_d = grant;
    last_d  = last_q;
    cnt_d   = cnt_q;
    x_d     = '0;
    tag_in  = '0;
`ifdef FIR_ARB_TIMEOUT_EN
    stall_d = '0;
    abort_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = NREQ'(1) << win;
          last_d  = win;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (acc) begin
          x_d          = s_data_a[last_q];
          tag_in.valid = 1'b1;
          tag_in.id    = last_q;
          tag_in.last  = s_last[last_q];
          if (s_last[last_q]) begin
            grant_d = '0;
            cnt_d   = CW'(TAPS - 1);
            state_d = FLUSH;
          end
        end
`ifdef FIR_ARB_TIMEOUT_EN
        else if (stall_q == SW'(TIMEOUT - 1)) begin
          grant_d = '0;
          cnt_d   = CW'(TAPS - 1);
          abort_d = 1'b1;
          state_d = FLUSH;
        end else begin
          stall_d = stall_q + SW'(1);
        end
`endif
      end
      FLUSH: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, grant, filter input and tag pipe registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant   <= '0;
      last_q  <= IDW'(NREQ - 1);
      cnt_q   <= '0;
      fir_x   <= '0;
      for (int i = 0; i <= FIR_LAT; i++) tag_q[i] <= '0;
`ifdef FIR_ARB_TIMEOUT_EN
      stall_q <= '0;
      abort   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      grant    <= grant_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      fir_x    <= x_d;
      tag_q[0] <= tag_in;
      for (int i = 1; i <= FIR_LAT; i++) tag_q[i] <= tag_q[i-1];
`ifdef FIR_ARB_TIMEOUT_EN
      stall_q  <= stall_d;
      abort    <= abort_d;
`endif
    end
  end

endmodule
